ex_hazard_ctrl: RTL

Pipeline sequencing controller for the execute stage of the RISC-V core. Detects load-use hazards that the forwarding path cannot cover, squashes younger instructions when a jump or taken branch resolves in EX, and freezes the whole pipeline while data memory or UART is busy. Sits beside the ex stage and drives stall, bubble, flush and redirect controls to the IF/ID and ID/EX pipeline registers.

---
 rtl/ex_hazard_ctrl_pkg.sv | 16 +
 rtl/ex_hazard_detect.sv | 25 ++
 rtl/ex_hazard_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the execute-stage hazard controller: FSM state
// encodings and the register-address bus width.
package ex_hazard_ctrl_pkg;

  localparam int REG_ABUS = 5;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_REDIRECT   = 2'd2,
    HZ_MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam logic [7:0] BCNT_SAT = 8'd255;

endpackage

// File: rtl/ex_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load still in EX (x0 never hazards).
module ex_hazard_detect
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [REG_ABUS-1:0] i_rs1_addr,
  input  logic [REG_ABUS-1:0] i_rs2_addr,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic                i_ex_valid,
  input  logic                i_ex_is_load,
  input  logic [REG_ABUS-1:0] i_ex_wb_addr,
  output logic                o_hazard
);

  logic w_load_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_load_live = i_ex_valid & i_ex_is_load & (i_ex_wb_addr != '0);
  assign w_rs1_hit   = i_rs1_used & (i_rs1_addr == i_ex_wb_addr);
  assign w_rs2_hit   = i_rs2_used & (i_rs2_addr == i_ex_wb_addr);
  assign o_hazard    = w_load_live & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencing controller: load-use stalls, redirect flushes and
// memory-busy freezes. Optional perf counters under EX_HAZARD_PERF_EN.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 1,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_WAIT_MAX      = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ABUS-1:0] id_rs1_addr_i,
  input  logic [REG_ABUS-1:0] id_rs2_addr_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic                ex_valid_i,
  input  logic                ex_is_load_i,
  input  logic [REG_ABUS-1:0] ex_wb_addr_i,
  input  logic                ex_redirect_i,
  input  logic                mem_busy_i,
  output logic                stall_if_o,
  output logic                stall_id_o,
  output logic                bubble_ex_o,
  output logic                flush_id_o,
  output logic                pc_redirect_o,
  output logic                freeze_o,
  output logic                mem_timeout_o,
  output logic [1:0]          state_o
`ifdef EX_HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt_o,
  output logic [31:0]         perf_flush_cnt_o,
  output logic [31:0]         perf_freeze_cnt_o
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [2:0] STALL_RELOAD = 3'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_WAIT_MAX);

  hz_state_t  r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_bcnt;
  logic       r_timeout;

  hz_state_t  w_state_nxt;
  logic [2:0] w_cnt_nxt;
  logic [7:0] w_bcnt_nxt;
  logic       w_hazard;
  logic       w_stall;
  logic       w_flush;
  logic       w_redir;
  logic       w_freeze;
  logic       w_busy_tick;
  logic       w_timeout_set;

  ex_hazard_detect u_detect (
    .i_rs1_addr   (id_rs1_addr_i),
    .i_rs2_addr   (id_rs2_addr_i),
    .i_rs1_used   (id_rs1_used_i),
    .i_rs2_used   (id_rs2_used_i),
    .i_ex_valid   (ex_valid_i),
    .i_ex_is_load (ex_is_load_i),
    .i_ex_wb_addr (ex_wb_addr_i),
    .o_hazard     (w_hazard)
  );

  // w_busy_tick marks a busy cycle that belongs to a freeze episode and
  // therefore advances the timeout counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_redir     = 1'b0;
    w_freeze    = 1'b0;
    w_busy_tick = 1'b0;
    unique case (r_state)
      HZ_RUN: begin
        if (mem_busy_i) begin
          w_freeze    = 1'b1;
          w_busy_tick = 1'b1;
          w_bcnt_nxt  = 8'd1;
          w_state_nxt = HZ_MEM_WAIT;
        end else if (ex_redirect_i) begin
          w_redir = 1'b1;
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = HZ_REDIRECT;
            w_cnt_nxt   = FLUSH_RELOAD;
          end
        end else if (w_hazard) begin
          w_stall = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = HZ_LOAD_STALL;
            w_cnt_nxt   = STALL_RELOAD;
          end
        end
      end
      HZ_LOAD_STALL: begin
        if (mem_busy_i) begin
          w_freeze    = 1'b1;
          w_busy_tick = 1'b1;
          w_bcnt_nxt  = 8'd1;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = HZ_MEM_WAIT;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == 3'd0) w_state_nxt = HZ_RUN;
          else               w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      HZ_REDIRECT: begin
        if (mem_busy_i) begin
          w_freeze = 1'b1;
        end else begin
          w_flush = 1'b1;
          if (r_cnt == 3'd0) w_state_nxt = HZ_RUN;
          else               w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_busy_i) begin
          w_freeze    = 1'b1;
          w_busy_tick = 1'b1;
          if (r_bcnt != BCNT_SAT) w_bcnt_nxt = r_bcnt + 8'd1;
        end else begin
          w_state_nxt = HZ_RUN;
        end
      end
      default: w_state_nxt = HZ_RUN;
    endcase
  end

  assign w_timeout_set = w_busy_tick & (w_bcnt_nxt >= WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HZ_RUN;
      r_cnt     <= 3'd0;
      r_bcnt    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  // Reset forces every output low in the cycle it is asserted.
  assign stall_if_o    = ~rst & w_stall;
  assign stall_id_o    = ~rst & w_stall;
  assign bubble_ex_o   = ~rst & w_stall;
  assign flush_id_o    = ~rst & w_flush;
  assign pc_redirect_o = ~rst & w_redir;
  assign freeze_o      = ~rst & w_freeze;
  assign mem_timeout_o = ~rst & (r_timeout | w_timeout_set);
  assign state_o       = rst ? 2'd0 : r_state;

`ifdef EX_HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall  <= 32'd0;
      r_perf_flush  <= 32'd0;
      r_perf_freeze <= 32'd0;
    end else begin
      if (bubble_ex_o) r_perf_stall  <= r_perf_stall + 32'd1;
      if (flush_id_o)  r_perf_flush  <= r_perf_flush + 32'd1;
      if (freeze_o)    r_perf_freeze <= r_perf_freeze + 32'd1;
    end
  end

  assign perf_stall_cnt_o  = r_perf_stall;
  assign perf_flush_cnt_o  = r_perf_flush;
  assign perf_freeze_cnt_o = r_perf_freeze;
`endif

endmodule
